clk_tick_gen: RTL and testbench



---
 rtl/clk_tick_gen.sv | 140 ++++++++++++++
 tb/tb_clk_tick_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_gen.sv
//------------------------------------------------------------------------------
// clk_tick_gen
//
// Multi-channel clock-enable generator. Each of NCH channels divides the
// enabled clock by its own runtime-programmable integer divisor and emits a
// registered one-cycle tick plus (optionally) a 50%-duty square wave.
// Everything lives in the single clk domain.
//
// Parameters:
//   NCH      number of channels (1..16)
//   CW       divisor / counter width in bits
//   DIV_INIT divisor loaded into every channel at reset (must fit in CW bits)
//
// Ports:
//   clk      in   system clock
//   RESETn   in   asynchronous active-low reset
//   en       in   global run; counters advance only while high
//   sync     in   single-cycle restart of all channels (beats en and wrap)
//   cfg_we   in   divisor write strobe
//   cfg_ch   in   [CHW]  target channel; values >= NCH are ignored
//   cfg_div  in   [CW]   new divisor (0 halts the channel)
//   tick     out  [NCH]  one-cycle enable pulse per channel
//   sq       out  [NCH]  square wave per channel, toggles on each tick
//   pending  out  [NCH]  a written divisor is waiting for the next wrap
//
// Build option:
//   CLK_TICK_SQUARE_EN  when defined, the sq toggle flops are built; when
//                       undefined, sq is tied to 0.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module clk_tick_gen #(
   parameter int NCH      = 4,
   parameter int CW       = 16,
   parameter int DIV_INIT = 50000,
   localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           RESETn,
   input  logic           en,
   input  logic           sync,
   input  logic           cfg_we,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [CW-1:0]  cfg_div,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] sq,
   output logic [NCH-1:0] pending
);

   localparam logic [CW-1:0] DIV_RST = CW'(DIV_INIT);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [CW-1:0] cnt;
      logic [CW-1:0] act;
      logic [CW-1:0] shd;
      logic          pnd;
      logic          tick_r;
      logic          halted;
      logic          wrap;
      logic          hit;

      assign halted = (act == '0);
      // cnt never exceeds act-1 because act only changes while cnt is 0,
      // so an equality compare is enough to detect the end of a period.
      assign wrap   = en && !halted && (cnt == act - CW'(1));
      // An out-of-range cfg_ch matches no channel index, so it is dropped.
      assign hit    = cfg_we && (cfg_ch == CHW'(i));

      // NOTE: every flop, divisor registers included, is cleared by reset so a
      // reset mid-count also throws away any pending write.
      always_ff @(posedge clk or negedge RESETn) begin
         if (!RESETn) begin
            cnt    <= '0;
            act    <= DIV_RST;
            shd    <= DIV_RST;
            pnd    <= 1'b0;
            tick_r <= 1'b0;
         end else if (sync) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            cnt    <= '0;
            tick_r <= 1'b0;
            pnd    <= 1'b0;
            if (hit) begin
               shd <= cfg_div;
               act <= cfg_div;
            end else if (pnd) begin
               act <= shd;
            end
         end else begin
            if (wrap) begin
               cnt    <= '0;
               tick_r <= 1'b1;
            end else begin
               tick_r <= 1'b0;
               if (en && !halted) begin
                  cnt <= cnt + CW'(1);
               end
            end

            if (hit) begin
               shd <= cfg_div;
               // Apply at once when the channel is at a period boundary or
               // halted; otherwise defer to the next wrap.
               if (wrap || halted) begin
                  act <= cfg_div;
                  pnd <= 1'b0;
               end else begin
                  pnd <= 1'b1;
               end
            end else if (wrap && pnd) begin
               act <= shd;
               pnd <= 1'b0;
            end
         end
      end

      assign tick[i]    = tick_r;
      assign pending[i] = pnd;

`ifdef CLK_TICK_SQUARE_EN
      logic sq_r;

      always_ff @(posedge clk or negedge RESETn) begin
         if (!RESETn) begin
            sq_r <= 1'b0;
         end else if (sync) begin
            sq_r <= 1'b0;
         end else if (wrap) begin
            sq_r <= ~sq_r;
         end
      end

      assign sq[i] = sq_r;
`else
      assign sq[i] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_clk_tick_gen.sv
//------------------------------------------------------------------------------
// tb_clk_tick_gen
//
// Drives two clk_tick_gen instances from the same stimulus: a 4-channel one
// and a 3-channel one (so that cfg_ch = 3 is an out-of-range channel). A
// behavioural model of each channel predicts tick/sq/pending after every
// clock edge; predictions go into a queue and a monitor compares them with
// the DUT outputs on the falling edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clk_tick_gen;

   localparam int CW   = 8;
   localparam int DINI = 5;

   logic       clk = 1'b0;
   logic       RESETn = 1'b0;
   logic       en = 1'b0;
   logic       sync = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_ch = '0;
   logic [7:0] cfg_div = '0;

   logic [3:0] tick4, sq4, pend4;
   logic [2:0] tick3, sq3, pend3;

   always #5 clk = ~clk;

   clk_tick_gen #(.NCH(4), .CW(CW), .DIV_INIT(DINI)) dut4 (
      .clk(clk), .RESETn(RESETn), .en(en), .sync(sync),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .tick(tick4), .sq(sq4), .pending(pend4)
   );

   clk_tick_gen #(.NCH(3), .CW(CW), .DIV_INIT(DINI)) dut3 (
      .clk(clk), .RESETn(RESETn), .en(en), .sync(sync),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .tick(tick3), .sq(sq3), .pending(pend3)
   );

   // ---------------- reference model ----------------
   // A channel is "ticks every act enabled cycles"; pos counts enabled cycles
   // since the last tick.
   typedef struct {
      int pos;
      int act;
      int shd;
      bit pnd;
      bit tick;
      bit sq;
   } chan_t;

   chan_t m[2][4];

   typedef struct {
      int         cyc;
      logic [3:0] tick4, sq4, pend4;
      logic [2:0] tick3, sq3, pend3;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   function automatic int nch_of(int k);
      return (k == 0) ? 4 : 3;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 4; i++)
            m[k][i] = '{pos: 0, act: DINI, shd: DINI, pnd: 1'b0, tick: 1'b0, sq: 1'b0};
   endtask

   task automatic model_step(bit en_v, bit sync_v, bit we_v, int ch_v, int div_v);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < nch_of(k); i++) begin
            chan_t c;
            bit    ends_period;
            bit    written;
            c = m[k][i];
            written = we_v && (ch_v == i);
            ends_period = en_v && (c.act > 0) && (c.pos + 1 == c.act);
            if (sync_v) begin
               c.pos = 0; c.tick = 0; c.sq = 0;
               if (written) begin c.shd = div_v; c.act = div_v; end
               else if (c.pnd) c.act = c.shd;
               c.pnd = 0;
            end else begin
               c.tick = ends_period;
               if (ends_period) begin
                  c.pos = 0;
                  c.sq  = !c.sq;
               end else if (en_v && c.act > 0) begin
                  c.pos = c.pos + 1;
               end
               if (written) begin
                  c.shd = div_v;
                  if (ends_period || c.act == 0) begin c.act = div_v; c.pnd = 0; end
                  else c.pnd = 1;
               end else if (ends_period && c.pnd) begin
                  c.act = c.shd; c.pnd = 0;
               end
            end
            m[k][i] = c;
         end
      end
   endtask

   task automatic push_expected();
      exp_t e;
      e.cyc = cyc;
      e.tick4 = '0; e.sq4 = '0; e.pend4 = '0;
      e.tick3 = '0; e.sq3 = '0; e.pend3 = '0;
      for (int i = 0; i < 4; i++) begin
         e.tick4[i] = m[0][i].tick;
         e.pend4[i] = m[0][i].pnd;
`ifdef CLK_TICK_SQUARE_EN
         e.sq4[i]   = m[0][i].sq;
`endif
      end
      for (int i = 0; i < 3; i++) begin
         e.tick3[i] = m[1][i].tick;
         e.pend3[i] = m[1][i].pnd;
`ifdef CLK_TICK_SQUARE_EN
         e.sq3[i]   = m[1][i].sq;
`endif
      end
      exp_q.push_back(e);
   endtask

   // ---------------- checking ----------------
   task automatic check(string name, int c, logic [3:0] got, logic [3:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s cycle %0d: got %b expected %b", name, c, got, want);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tick4",    e.cyc, tick4, e.tick4);
            check("sq4",      e.cyc, sq4,   e.sq4);
            check("pending4", e.cyc, pend4, e.pend4);
            check("tick3",    e.cyc, {1'b0, tick3}, {1'b0, e.tick3});
            check("sq3",      e.cyc, {1'b0, sq3},   {1'b0, e.sq3});
            check("pending3", e.cyc, {1'b0, pend3}, {1'b0, e.pend3});
         end
      end
   end

   // ---------------- stimulus ----------------
   // Inputs change just after the falling edge (after the monitor samples);
   // RESETn dropping there is an asynchronous assertion.
   task automatic step(bit rst_v, bit en_v, bit sync_v, bit we_v, int ch_v, int div_v);
      @(negedge clk);
      #1;
      RESETn  = rst_v;
      en      = en_v;
      sync    = sync_v;
      cfg_we  = we_v;
      cfg_ch  = 2'(ch_v);
      cfg_div = 8'(div_v);
      @(posedge clk);
      cyc++;
      if (!rst_v) model_reset();
      else model_step(en_v, sync_v, we_v, ch_v, div_v);
      push_expected();
   endtask

   task automatic run(int n, bit en_v);
      for (int j = 0; j < n; j++) step(1'b1, en_v, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic wr(int ch_v, int div_v);
      step(1'b1, 1'b1, 1'b0, 1'b1, ch_v, div_v);
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : driver
      model_reset();
      // Reset, then free-run at the default divisor.
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      run(16, 1'b1);

      // Runtime divisor change on ch1 mid-period.
      wr(1, 3);
      run(16, 1'b1);

      // Halt ch2, then resume it with divisor 4.
      wr(2, 0);
      run(12, 1'b1);
      wr(2, 4);
      run(10, 1'b1);

      // en gap of 7 cycles mid-count.
      run(2, 1'b1);
      run(7, 1'b0);
      run(8, 1'b1);

      // ch3: active 6, then a pending 2, then sync.
      wr(3, 6);
      run(10, 1'b1);
      wr(3, 2);
      step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
      run(12, 1'b1);

      // sync coinciding with a write.
      step(1'b1, 1'b1, 1'b1, 1'b1, 1, 7);
      run(9, 1'b1);

      // Divisor 1 on ch0: tick stuck high.
      wr(0, 1);
      run(8, 1'b1);
      run(2, 1'b0);
      run(3, 1'b1);

      // cfg_ch = 3 is out of range for the 3-channel instance.
      wr(3, 9);
      run(12, 1'b1);

      // Reset mid-count with a pending write.
      wr(1, 9);
      run(2, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      run(16, 1'b1);

      // Randomised traffic.
      for (int j = 0; j < 500; j++) begin
         bit en_r, sy_r, we_r, rs_r;
         en_r = ($urandom_range(0, 9) != 0);
         sy_r = ($urandom_range(0, 39) == 0);
         we_r = ($urandom_range(0, 4) == 0);
         rs_r = ($urandom_range(0, 199) != 0);
         step(rs_r, en_r, sy_r, we_r, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
      end

      run(3, 1'b1);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL queue_drained: got %0d entries left expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
